// File: rtl/lsx_counter.sv
// ---------------------------------------------------------------------------
// lsx_counter
//
// Purpose:
//   Parametrised synchronous modulo counter in the style of a 74x161, extended
//   with the following features:
//     - a configurable width and modulus,
//     - up/down counting,
//     - a synchronous clear,
//     - clamping of parallel-load values,
//     - a registered one-cycle wrap pulse.
//   It keeps the ENP/ENT cascade scheme. To chain stages, feed the RCO of
//   stage N into the ENT of stage N+1 and share ENP between stages; the chain
//   then counts modulo MODULUS**k.
//
// Parameters:
//   WIDTH    counter width in bits (1..32).
//   MODULUS  count length; the counter counts 0..MODULUS-1 (2..2**WIDTH).
//
// Ports:
//   CLK     in   1      clock, rising edge active
//   CLR_n   in   1      asynchronous active-low reset (Q=0, WRAP=0)
//   SCLR_n  in   1      synchronous active-low clear (highest edge priority)
//   LOAD_n  in   1      synchronous active-low load of D (clamped)
//   D       in   WIDTH  parallel load value
//   ENP     in   1      parallel count enable
//   ENT     in   1      trickle count enable; also gates RCO
//   UP      in   1      1 = count up, 0 = count down
//   CMP     in   WIDTH  compare value       (only with LSX_COUNTER_MATCH_EN)
//   MATCH   out  1      sticky compare flag (only with LSX_COUNTER_MATCH_EN)
//   Q       out  WIDTH  counter value
//   RCO     out  1      terminal count, combinational: ENT & (Q == TC)
//   WRAP    out  1      one-cycle pulse after a counting edge that wrapped
//
// Optional feature macro: LSX_COUNTER_MATCH_EN
//   Define it to add the CMP input and the MATCH output.
//   When it is undefined, those ports do not exist and the rest of the
//   counter behaves the same.
// ---------------------------------------------------------------------------
module lsx_counter #(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic             SCLR_n,
    input  logic             LOAD_n,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    input  logic             UP,
`ifdef LSX_COUNTER_MATCH_EN
    input  logic [WIDTH-1:0] CMP,
    output logic             MATCH,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             RCO,
    output logic             WRAP
);

    // Reject illegal parameterisations at elaboration time.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("lsx_counter: WIDTH must be in 1..32");
    end
    if (MODULUS < 2 || MODULUS > (64'sd1 <<< WIDTH)) begin : g_bad_modulus
        $error("lsx_counter: MODULUS must be in 2..2**WIDTH");
    end

    // Largest legal count value (MODULUS-1), computed in 64 bits so that
    // MODULUS = 2**32 is representable, then truncated to the counter width.
    localparam longint           MAX_L   = MODULUS - 1;
    localparam logic [WIDTH-1:0] MAX_VAL = MAX_L[WIDTH-1:0];

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] tc;
    logic             count_en;

    // Terminal value depends on direction. UP acts on RCO immediately.
    assign tc       = UP ? MAX_VAL : '0;
    assign count_en = ENP & ENT;

    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (!SCLR_n) begin
            q_d = '0;
        end else if (!LOAD_n) begin
            // Out-of-range loads clamp to the top of the count range.
            q_d = (D > MAX_VAL) ? MAX_VAL : D;
        end else if (count_en) begin
            if (UP) begin
                // Use >= rather than == so that any out-of-range value
                // recovers to 0 on the next count edge.
                if (q_q >= MAX_VAL) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (q_q == '0) begin
                    q_d    = MAX_VAL;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q    = q_q;
    assign WRAP = wrap_q;
    assign RCO  = ENT & (q_q == tc);

`ifdef LSX_COUNTER_MATCH_EN
    // Sticky flag. A Q==CMP value seen at an edge sets the flag on that same
    // edge. Clear and load win over a match that happens in the same cycle.
    logic match_q, match_d;

    always_comb begin
        match_d = match_q;
        if (!SCLR_n || !LOAD_n) begin
            match_d = 1'b0;
        end else if (q_q == CMP) begin
            match_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign MATCH = match_q;
`endif

endmodule

// File: tb/tb_lsx_counter.sv
// ---------------------------------------------------------------------------
// tb_lsx_counter
//
// This bench drives directed stimulus into three instances:
//   - u_dec:   a decade counter (WIDTH=4, MODULUS=10),
//   - u_lo and u_hi: two binary stages (WIDTH=4, MODULUS=16) cascaded
//     through RCO -> ENT.
//
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, after the edge has settled.
// ---------------------------------------------------------------------------
module tb_lsx_counter;

    // Clock and reset
    logic clk;
    logic clr_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decade counter under test
    logic       sclr_n, load_n, enp, ent, up;
    logic [3:0] d, q;
    logic       rco, wrap;
`ifdef LSX_COUNTER_MATCH_EN
    logic [3:0] cmp;
    logic       match;
`endif

    lsx_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
        .CLK    (clk),
        .CLR_n  (clr_n),
        .SCLR_n (sclr_n),
        .LOAD_n (load_n),
        .D      (d),
        .ENP    (enp),
        .ENT    (ent),
        .UP     (up),
`ifdef LSX_COUNTER_MATCH_EN
        .CMP    (cmp),
        .MATCH  (match),
`endif
        .Q      (q),
        .RCO    (rco),
        .WRAP   (wrap)
    );

    // Two-stage binary cascade
    logic       c_sclr_n, c_load_n, c_enp, c_ent, c_up;
    logic [3:0] d_lo, d_hi, q_lo, q_hi;
    logic       rco_lo, rco_hi, wrap_lo, wrap_hi;
`ifdef LSX_COUNTER_MATCH_EN
    logic [3:0] c_cmp;
    logic       match_lo, match_hi;
`endif

    lsx_counter #(.WIDTH(4), .MODULUS(16)) u_lo (
        .CLK    (clk),
        .CLR_n  (clr_n),
        .SCLR_n (c_sclr_n),
        .LOAD_n (c_load_n),
        .D      (d_lo),
        .ENP    (c_enp),
        .ENT    (c_ent),
        .UP     (c_up),
`ifdef LSX_COUNTER_MATCH_EN
        .CMP    (c_cmp),
        .MATCH  (match_lo),
`endif
        .Q      (q_lo),
        .RCO    (rco_lo),
        .WRAP   (wrap_lo)
    );

    lsx_counter #(.WIDTH(4), .MODULUS(16)) u_hi (
        .CLK    (clk),
        .CLR_n  (clr_n),
        .SCLR_n (c_sclr_n),
        .LOAD_n (c_load_n),
        .D      (d_hi),
        .ENP    (c_enp),
        .ENT    (rco_lo),
        .UP     (c_up),
`ifdef LSX_COUNTER_MATCH_EN
        .CMP    (c_cmp),
        .MATCH  (match_hi),
`endif
        .Q      (q_hi),
        .RCO    (rco_hi),
        .WRAP   (wrap_hi)
    );

    // Scoreboard counters
    int tests_run = 0;
    int tests_failed = 0;

    // Expected Q after each of 12 up-count edges from reset
    localparam logic [3:0] UP_EXP [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                          4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    // Expected Q after each of 5 down-count edges following a load of 3
    localparam logic [3:0] DN_EXP [5]  = '{4'd2, 4'd1, 4'd0, 4'd9, 4'd8};

    // Check helpers
    task automatic chk_v(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        clr_n    = 1'b0;
        sclr_n   = 1'b1; load_n = 1'b1; d = 4'd0;
        enp      = 1'b1; ent = 1'b0; up = 1'b1;
        c_sclr_n = 1'b1; c_load_n = 1'b1; d_lo = 4'd0; d_hi = 4'd0;
        c_enp    = 1'b0; c_ent = 1'b0; c_up = 1'b1;
`ifdef LSX_COUNTER_MATCH_EN
        cmp   = 4'd4;
        c_cmp = 4'd0;
`endif

        // Reset state; RCO reads ENT & ~UP while in reset.
        #1;
        chk_v("reset_q", q, 4'd0);
        chk_b("reset_wrap", wrap, 1'b0);
        chk_b("reset_rco_ent0", rco, 1'b0);
`ifdef LSX_COUNTER_MATCH_EN
        chk_b("reset_match", match, 1'b0);
`endif
        ent = 1'b1; up = 1'b0;
        #0.5;
        chk_b("reset_rco_down", rco, 1'b1);
        up = 1'b1;
        #0.5;
        chk_b("reset_rco_up", rco, 1'b0);
        clr_n = 1'b1;

        // Up-count 12 edges from reset.
        for (int i = 0; i < 12; i++) begin
            step();
            chk_v($sformatf("up_q[%0d]", i), q, UP_EXP[i]);
            chk_b($sformatf("up_rco[%0d]", i), rco, (i == 8));
            chk_b($sformatf("up_wrap[%0d]", i), wrap, (i == 9));
`ifdef LSX_COUNTER_MATCH_EN
            // Q reaches 4 after edge index 3, so MATCH sets on edge index 4.
            chk_b($sformatf("up_match[%0d]", i), match, (i >= 4));
`endif
        end

        // Down-count: load 3, then 5 count edges.
        up = 1'b0; load_n = 1'b0; d = 4'd3;
        step();
        chk_v("dn_load_q", q, 4'd3);
        chk_b("dn_load_wrap", wrap, 1'b0);
`ifdef LSX_COUNTER_MATCH_EN
        chk_b("load_clears_match", match, 1'b0);
`endif
        load_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_v($sformatf("dn_q[%0d]", i), q, DN_EXP[i]);
            chk_b($sformatf("dn_rco[%0d]", i), rco, (i == 2));
            chk_b($sformatf("dn_wrap[%0d]", i), wrap, (i == 3));
        end

        // Load clamp, then clear and load on the same edge.
        up = 1'b1; enp = 1'b0; load_n = 1'b0; d = 4'd13;
        step();
        chk_v("clamp_q", q, 4'd9);
        chk_b("clamp_rco", rco, 1'b1);
        sclr_n = 1'b0; d = 4'd5;
        step();
        chk_v("sclr_over_load_q", q, 4'd0);
        chk_b("sclr_wrap", wrap, 1'b0);

        // Enable gating at Q=9.
        sclr_n = 1'b1; d = 4'd9;
        step();
        load_n = 1'b1; enp = 1'b0; ent = 1'b1;
        step();
        chk_v("enp0_hold_q", q, 4'd9);
        chk_b("enp0_rco", rco, 1'b1);
        chk_b("enp0_wrap", wrap, 1'b0);
        up = 1'b0;
        #1;
        chk_b("up_change_rco", rco, 1'b0);
        up = 1'b1; enp = 1'b1; ent = 1'b0;
        #1;
        chk_b("ent0_rco", rco, 1'b0);
        step();
        chk_v("ent0_hold_q", q, 4'd9);

        // Wrap pulse, then reset mid-cycle while WRAP is high.
        ent = 1'b1;
        step();
        chk_v("wrap_q", q, 4'd0);
        chk_b("wrap_pulse", wrap, 1'b1);
        #3;
        clr_n = 1'b0;
        #1;
        chk_b("async_rst_wrap", wrap, 1'b0);
        clr_n = 1'b1;

        // Reset mid-cycle with Q=6.
        load_n = 1'b0; d = 4'd6;
        step();
        chk_v("pre_rst_q", q, 4'd6);
        load_n = 1'b1;
        #3;
        clr_n = 1'b0;
        #1;
        chk_v("async_rst_q", q, 4'd0);
        chk_b("async_rst_wrap2", wrap, 1'b0);
        #1;
        clr_n = 1'b1;
        step();
        chk_v("resume_q", q, 4'd1);

        // Two-stage cascade: 0x0F -> 0x10 -> 0x11.
        c_load_n = 1'b0; d_lo = 4'hF; d_hi = 4'h0; c_enp = 1'b1; c_ent = 1'b1;
        step();
        chk_v("casc_load_lo", q_lo, 4'hF);
        chk_v("casc_load_hi", q_hi, 4'h0);
        chk_b("casc_rco_lo", rco_lo, 1'b1);
        c_load_n = 1'b1;
        step();
        chk_v("casc_lo_0", q_lo, 4'h0);
        chk_v("casc_hi_1", q_hi, 4'h1);
        step();
        chk_v("casc_lo_1", q_lo, 4'h1);
        chk_v("casc_hi_hold", q_hi, 4'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Overall time bound: the directed sequence is short.
    initial begin
        #5000;
        $display("FAIL timeout: sequence did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsx_counter.md
Name: lsx_counter

Overview:
- Parametrised synchronous counter; next generation of the team's 4-bit 74x161-style counter.
- Generalises width and modulus (binary or decade/arbitrary modulus).
- Adds up/down counting, synchronous clear, input range clamping and a registered wrap pulse.
- Keeps the ENP/ENT cascade scheme so wider counters chain RCO to the next stage's ENT.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..32.
- MODULUS, 16, count length; counts 0..MODULUS-1; legal range 2..2**WIDTH; an illegal value is a compile-time error.

Ports:
- CLK  input  1  clock; rising edge active.
- CLR_n  input  1  asynchronous active-low reset.
- SCLR_n  input  1  synchronous active-low clear.
- LOAD_n  input  1  synchronous active-low parallel load.
- D  input  WIDTH  parallel load value.
- ENP  input  1  count enable, parallel.
- ENT  input  1  count enable, trickle; also gates RCO.
- UP  input  1  direction: 1 = count up, 0 = count down.
- Q  output  WIDTH  counter value.
- RCO  output  1  ripple carry / terminal count (combinational).
- WRAP  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- Reset (CLR_n=0), asynchronous and overriding everything: Q=0, WRAP=0. RCO follows its equation, so it reads ENT & ~UP while in reset.
- Terminal value TC: MODULUS-1 when UP=1; 0 when UP=0.
- RCO = ENT & (Q==TC). Combinational; no dependence on ENP.
- Per rising CLK edge with CLR_n=1, priority highest first:
  1. SCLR_n=0: Q<=0.
  2. LOAD_n=0: Q<=D if D<=MODULUS-1; otherwise Q<=MODULUS-1 (clamp).
  3. ENP=1 and ENT=1, UP=1: Q<=0 if Q>=MODULUS-1, else Q+1.
  4. ENP=1 and ENT=1, UP=0: Q<=MODULUS-1 if Q==0, else Q-1.
  5. Otherwise: hold.
- WRAP: registered. Set to 1 for exactly one cycle after an edge where a count (step 3 or 4) took the wrap branch. It is 0 after clear, load or hold edges.
- Latency:
  - Q updates on the same edge as the inputs are sampled.
  - WRAP is asserted in the cycle following that edge, coincident with the new Q.
- UP changes take effect at the next edge; RCO re-evaluates immediately.
- Out-of-range Q cannot occur: load clamps it and reset gives 0. The >= comparison in step 3 is defensive.
- Simultaneous SCLR_n=0 and LOAD_n=0: clear wins, Q=0.
- Reset asserted mid-count: Q=0 immediately, without waiting for a clock edge. After CLR_n releases, counting resumes on the first edge with enables high.
- Cascading: stage N+1 ENT = stage N RCO, and ENP is shared. The chain then counts as a MODULUS**k counter with no extra logic.
- MODULUS = 2**WIDTH: natural binary wrap, and clamping is never active.

Optional Feature:
- Macro: LSX_COUNTER_MATCH_EN.
- Defined, adds two ports:
  - CMP (input, WIDTH): compare value.
  - MATCH (output, 1): sticky flag.
- MATCH is set on the edge after Q==CMP is first observed while CLR_n=1.
- MATCH is cleared by CLR_n=0, SCLR_n=0 or LOAD_n=0; otherwise it holds.
- If a clear/load and a match occur in the same cycle, the clear wins.
- MATCH reset value is 0.
- Undefined: CMP and MATCH ports are absent; the remaining behaviour is unchanged.

Test Plan:
- WIDTH=4, MODULUS=10, UP=1, ENP=ENT=1, 12 edges from reset → Q: 1..9, 0, 1, 2.
  - RCO=1 only while Q=9.
  - WRAP=1 only in the cycle Q=0 follows 9.
- Same configuration, UP=0, load D=3, then 5 count edges → Q: 3, 2, 1, 0, 9, 8.
  - RCO=1 while Q=0.
  - WRAP pulses once, when Q becomes 9.
- LOAD_n=0 with D=13 (MODULUS=10) → Q=9.
  - Then SCLR_n=0 and LOAD_n=0 with D=5 on the same edge → Q=0.
- Enable gating at Q=9:
  - ENP=0, ENT=1: Q holds at 9, RCO=1.
  - ENT=0: RCO=0 and Q holds.
- Two WIDTH=4, MODULUS=16 stages cascaded, loaded 0x0F/0x00 (low/high), one count edge → 0x10.
  - The high stage increments only on that edge.
- Drive CLR_n=0 mid-cycle with Q=6 → Q=0 and WRAP=0 before the next edge.
  - With LSX_COUNTER_MATCH_EN defined and CMP=4: MATCH=1 one edge after Q=4, held after that, cleared by LOAD_n.
